bs_gnrtr_n_rbtr: RTL and testbench

Bus generator and arbiter: a shared packet bus connecting `drvrs` agents, each seen through a FIFO-style port. It grants one pending agent at a time in round-robin order and pops one packet from that agent. It then routes the packet to the destination agent (or to all other agents on broadcast) by pushing it into their receive side. It sits between the per-agent interface FIFOs and forms the only interconnect between them.

---
 rtl/bs_gnrtr_n_rbtr.sv | 132 +++++++++++++
 tb/tb_bs_gnrtr_n_rbtr.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bs_gnrtr_n_rbtr.sv
// Shared packet bus: round-robin grant over per-agent transmit FIFOs, one packet
// in flight at a time, routed by destination ID (unicast, broadcast or drop).
module bs_gnrtr_n_rbtr #(
    parameter int unsigned drvrs     = 4,
    parameter int unsigned pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [drvrs-1:0]         pndng,
    input  logic [drvrs*pckg_sz-1:0] D_pop,
    output logic [drvrs-1:0]         pop,
    output logic [drvrs-1:0]         push,
    output logic [drvrs*pckg_sz-1:0] D_push
);

    localparam int unsigned SRC_W = (drvrs > 1) ? $clog2(drvrs) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [SRC_W-1:0]         r_rr;
    logic [SRC_W-1:0]         w_rr_nxt;
    logic [SRC_W-1:0]         r_src;
    logic [SRC_W-1:0]         w_src_nxt;
    logic [pckg_sz-1:0]       r_pkt;
    logic [pckg_sz-1:0]       w_pkt_nxt;
    logic [drvrs-1:0]         r_pop;
    logic [drvrs-1:0]         w_pop_nxt;
    logic [drvrs-1:0]         r_push;
    logic [drvrs-1:0]         w_push_nxt;
    logic [drvrs*pckg_sz-1:0] r_d_push;
    logic [drvrs*pckg_sz-1:0] w_d_push_nxt;

    logic                     w_grant;
    logic [SRC_W-1:0]         w_gnt_idx;
    logic [pckg_sz-1:0]       w_gnt_pkt;
    logic [7:0]               w_dest;

    // (base + ofs) mod drvrs, for ofs < drvrs
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                  input int unsigned    ofs);
        int unsigned sum;
        sum = 32'(base) + ofs;
        if (sum >= drvrs) begin
            sum = sum - drvrs;
        end
        return SRC_W'(sum);
    endfunction

    // Round-robin search: first pending agent at or after the pointer
    always_comb begin
        w_grant   = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned k = 0; k < drvrs; k++) begin
            if (!w_grant && pndng[wrap_add(r_rr, k)]) begin
                w_grant   = 1'b1;
                w_gnt_idx = wrap_add(r_rr, k);
            end
        end
        w_gnt_pkt = D_pop[32'(w_gnt_idx)*pckg_sz +: pckg_sz];
    end

    assign w_dest = r_pkt[pckg_sz-1 -: 8];

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_nxt     = r_rr;
        w_src_nxt    = r_src;
        w_pkt_nxt    = r_pkt;
        w_pop_nxt    = '0;
        w_push_nxt   = '0;
        w_d_push_nxt = r_d_push;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_pop_nxt   = drvrs'(1) << w_gnt_idx;
                    w_pkt_nxt   = w_gnt_pkt;
                    w_src_nxt   = w_gnt_idx;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                w_d_push_nxt = {drvrs{r_pkt}};
                // Out-of-range destinations match no agent and are dropped
                for (int unsigned i = 0; i < drvrs; i++) begin
                    if (w_dest == broadcast) begin
                        w_push_nxt[i] = (SRC_W'(i) != r_src);
                    end else if (32'(w_dest) == i) begin
                        w_push_nxt[i] = 1'b1;
                    end
                end
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_rr_nxt    = wrap_add(r_src, 1);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_rr     <= '0;
            r_src    <= '0;
            r_pkt    <= '0;
            r_pop    <= '0;
            r_push   <= '0;
            r_d_push <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr     <= w_rr_nxt;
            r_src    <= w_src_nxt;
            r_pkt    <= w_pkt_nxt;
            r_pop    <= w_pop_nxt;
            r_push   <= w_push_nxt;
            r_d_push <= w_d_push_nxt;
        end
    end

    assign pop    = r_pop;
    assign push   = r_push;
    assign D_push = r_d_push;

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Bench for bs_gnrtr_n_rbtr: queue-based agent FIFOs and a transaction-level
// model of grant order, delivery mask and timing, plus directed scenarios.
module tb_bs_gnrtr_n_rbtr;

    localparam int         DRV   = 4;
    localparam int         PW    = 16;
    localparam logic [7:0] BCAST = 8'hFF;

    logic              clk = 1'b0;
    logic              reset;
    logic [DRV-1:0]    pndng;
    logic [DRV*PW-1:0] D_pop;
    logic [DRV-1:0]    pop;
    logic [DRV-1:0]    push;
    logic [DRV*PW-1:0] D_push;

    bs_gnrtr_n_rbtr #(
        .drvrs     (DRV),
        .pckg_sz   (PW),
        .broadcast (BCAST)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (D_pop),
        .pop    (pop),
        .push   (push),
        .D_push (D_push)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [PW-1:0]  txq [DRV][$];
    logic [DRV-1:0] en_mask = '1;
    int             checks = 0;
    int             errors = 0;

    // Transaction model state
    int             next_ok = 0;
    int             rr_m = 0;
    bit             sched_v = 1'b0;
    int             sched_cyc = 0;
    logic [DRV-1:0] sched_mask = '0;
    logic [PW-1:0]  sched_pkt = '0;
    logic [PW-1:0]  dsent = '0;
    int             g_agent[$];
    int             g_cyc[$];
    logic [DRV-1:0] last_pop = '0;
    logic [DRV-1:0] last_push = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DRV-1:0] exp_mask(input logic [PW-1:0] p, input int src);
        logic [7:0]     d;
        logic [DRV-1:0] m;
        d = p[PW-1 -: 8];
        m = '0;
        if (d == BCAST) begin
            for (int i = 0; i < DRV; i++) m[i] = (i != src);
        end else if (int'(d) < DRV) begin
            m[int'(d)] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [PW-1:0] rand_pkt();
        int         r;
        logic [7:0] d;
        r = $urandom_range(0, 5);
        if (r < DRV)      d = 8'(r);
        else if (r == 4)  d = BCAST;
        else              d = 8'($urandom_range(4, 254));
        return {d, 8'($urandom)};
    endfunction

    function automatic int total_q();
        int t;
        t = 0;
        for (int i = 0; i < DRV; i++) t += txq[i].size();
        return t;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < DRV; i++) begin
            pndng[i]          = (txq[i].size() != 0) && en_mask[i];
            D_pop[i*PW +: PW] = (txq[i].size() != 0) ? txq[i][0] : '0;
        end
    endtask

    // One cycle: predict this cycle's outputs, compare, then act as the FIFOs
    task automatic step();
        logic [DRV-1:0]    ap;
        logic [DRV-1:0]    ep;
        logic [DRV-1:0]    eph;
        logic [DRV*PW-1:0] heads;
        int                idx;
        @(negedge clk);
        ap    = pndng;
        heads = D_pop;
        ep    = '0;
        eph   = '0;
        if (reset) begin
            if (cyc >= next_ok && ap != '0) begin
                idx = -1;
                for (int k = 0; k < DRV; k++)
                    if (idx < 0 && ap[(rr_m + k) % DRV]) idx = (rr_m + k) % DRV;
                ep[idx]    = 1'b1;
                sched_v    = 1'b1;
                sched_cyc  = cyc + 1;
                sched_pkt  = heads[idx*PW +: PW];
                sched_mask = exp_mask(sched_pkt, idx);
                next_ok    = cyc + 3;
                rr_m       = (idx + 1) % DRV;
            end
            if (sched_v && sched_cyc == cyc) begin
                eph     = sched_mask;
                dsent   = sched_pkt;
                sched_v = 1'b0;
            end
        end else begin
            sched_v = 1'b0;
            rr_m    = 0;
            dsent   = '0;
            next_ok = cyc + 1;
        end
        chk("pop", 64'(pop), 64'(ep));
        chk("push", 64'(push), 64'(eph));
        chk("d_push", D_push, {DRV{dsent}});
        if (push != '0) last_push = push;
        if (pop != '0) begin
            last_pop = pop;
            for (int i = 0; i < DRV; i++) begin
                if (pop[i]) begin
                    g_agent.push_back(i);
                    g_cyc.push_back(cyc);
                    if (txq[i].size() != 0) void'(txq[i].pop_front());
                    else chk("pop_empty", 64'(i + 1), 64'd0);
                end
            end
        end
        drive_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  a;
        bit  found;
        reset = 1'b0;
        pndng = '0;
        D_pop = '0;
        repeat (3) step();
        reset = 1'b1;

        // Round robin under full load, each packet to (src+1)%4
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < DRV; i++)
                txq[i].push_back({8'((i + 1) % DRV), 8'(8'h30 + i + r * 4)});
        drive_inputs();
        g_agent.delete(); g_cyc.delete();
        repeat (30) step();
        chk("rr_count", 64'(g_agent.size()), 64'd8);
        for (int n = 0; n < 5; n++) chk($sformatf("rr_order%0d", n), 64'(g_agent[n]), 64'(n % DRV));
        for (int n = 1; n < 5; n++) chk($sformatf("rr_gap%0d", n), 64'(g_cyc[n] - g_cyc[n-1]), 64'd3);

        // Unicast 0 -> 2
        txq[0].push_back(16'h0214);
        drive_inputs();
        last_pop = '0; last_push = '0;
        repeat (5) step();
        chk("uni_pop", 64'(last_pop), 64'b0001);
        chk("uni_push", 64'(last_push), 64'b0100);

        // Broadcast from 1
        txq[1].push_back(16'hFF0A);
        drive_inputs();
        last_pop = '0; last_push = '0;
        repeat (5) step();
        chk("bc_pop", 64'(last_pop), 64'b0010);
        chk("bc_push", 64'(last_push), 64'b1101);

        // Invalid destination from 3, then agent 0 sends to itself
        txq[3].push_back(16'h0577);
        txq[0].push_back(16'h0014);
        drive_inputs();
        g_agent.delete(); g_cyc.delete(); last_push = '0;
        repeat (8) step();
        chk("inv_count", 64'(g_agent.size()), 64'd2);
        chk("inv_first", 64'(g_agent[0]), 64'd3);
        chk("inv_next", 64'(g_agent[1]), 64'd0);
        chk("inv_self", 64'(last_push), 64'b0001);

        // Reset while pop is high
        txq[0].push_back(16'h0101);
        txq[1].push_back(16'h0202);
        txq[1].push_back(16'h0303);
        drive_inputs();
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            step();
            found = (pop != '0);
        end
        chk("rst_wait_pop", 64'(found), 64'd1);
        chk("rst_gnt", 64'(pop), 64'b0010);
        #1 reset = 1'b0;
        #1;
        chk("rst_async_pop", 64'(pop), 64'd0);
        chk("rst_async_push", 64'(push), 64'd0);
        chk("rst_async_dpush", D_push, 64'd0);
        step();
        reset = 1'b1;
        g_agent.delete(); g_cyc.delete();
        repeat (8) step();
        chk("rst_first", 64'(g_agent[0]), 64'd0);
        chk("rst_second", 64'(g_agent[1]), 64'd1);

        // Idle, then two back-to-back packets from agent 2
        g_agent.delete(); g_cyc.delete();
        repeat (10) step();
        chk("idle_none", 64'(g_agent.size()), 64'd0);
        txq[2].push_back(16'h0011);
        txq[2].push_back(16'h0122);
        drive_inputs();
        repeat (10) step();
        chk("b2b_count", 64'(g_agent.size()), 64'd2);
        chk("b2b_agent", 64'(g_agent[1]), 64'd2);
        chk("b2b_gap", 64'(g_cyc[1] - g_cyc[0]), 64'd3);
        chk("b2b_last", 64'(last_push), 64'b0010);

        // Random traffic with occasional pending masking
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom_range(0, DRV - 1);
                if (txq[a].size() < 4) txq[a].push_back(rand_pkt());
            end
            en_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            drive_inputs();
            step();
        end
        en_mask = '1;
        drive_inputs();
        for (int n = 0; n < 200 && total_q() > 0; n++) step();
        repeat (4) step();
        chk("drain", 64'(total_q()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
